crc_stream_ctrl: RTL and testbench

Byte-stream sequencer for the bit-serial CRC datapath. It accepts bytes over a valid/ready handshake and serializes each byte MSB-first into a bit-serial CRC engine, one bit per clock. It frames messages using s_last and presents the finished CRC over a second valid/ready handshake. It also holds the runtime poly/init/xorout configuration and loads it only between frames.

---
 rtl/crc_stream_ctrl_pkg.sv | 14 +
 rtl/crc_stream_ctrl_if.sv | 25 ++
 rtl/crc_bit_engine.sv | 32 +++
 rtl/crc_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_crc_stream_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_stream_ctrl_pkg.sv
// Shared types and constants for the byte-stream CRC sequencer.
package crc_ctrl_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/crc_stream_ctrl_if.sv
// Byte input stream and CRC result stream, both valid/ready handshakes.
interface crc_stream_ctrl_if #(
   parameter int unsigned CRC_WIDTH = 8
);
   import crc_ctrl_pkg::*;

   logic [BYTE_W-1:0]    s_data;
   logic                 s_valid;
   logic                 s_last;
   logic                 s_ready;
   logic [CRC_WIDTH-1:0] crc_out;
   logic                 crc_valid;
   logic                 crc_ready;

   modport master (
      output s_data, s_valid, s_last, crc_ready,
      input  s_ready, crc_out, crc_valid
   );

   modport slave (
      input  s_data, s_valid, s_last, crc_ready,
      output s_ready, crc_out, crc_valid
   );

endinterface

// File: rtl/crc_bit_engine.sv
// Bit-serial CRC register: one unaugmented message bit per enabled clock.
module crc_bit_engine #(
   parameter int unsigned CRC_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [CRC_WIDTH-1:0] init,
   input  logic                 en,
   input  logic                 bit_in,
   input  logic [CRC_WIDTH-1:0] poly,
   output logic [CRC_WIDTH-1:0] crc
);

   logic [CRC_WIDTH-1:0] crc_q;
   logic                 fb;

   // crc is the post-step value so the caller can capture the result on the final bit
   assign fb  = crc_q[CRC_WIDTH-1] ^ bit_in;
   assign crc = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= '0;
      end else if (load) begin
         crc_q <= init;
      end else if (en) begin
         crc_q <= crc;
      end
   end

endmodule

// File: rtl/crc_stream_ctrl.sv
// Accepts bytes, serializes them MSB-first into the CRC engine, and
// presents the framed result; configuration is only taken between frames.
module crc_stream_ctrl
   import crc_ctrl_pkg::*;
#(
   parameter int unsigned          CRC_WIDTH      = 8,
   parameter logic [CRC_WIDTH-1:0] POLY_DEFAULT   = CRC_WIDTH'(8'h9B),
   parameter logic [CRC_WIDTH-1:0] INIT_DEFAULT   = CRC_WIDTH'(8'hFF),
   parameter logic [CRC_WIDTH-1:0] XOROUT_DEFAULT = CRC_WIDTH'(8'h00)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [CRC_WIDTH-1:0] cfg_poly,
   input  logic [CRC_WIDTH-1:0] cfg_init,
   input  logic [CRC_WIDTH-1:0] cfg_xorout,
   output logic                 cfg_busy,
   crc_stream_ctrl_if.slave     bus,
   input  logic                 abort,
   output logic [CNT_W-1:0]     byte_cnt
);

   state_t               state, state_nxt;
   logic [CRC_WIDTH-1:0] poly_q, init_q, xorout_q;
   logic [CRC_WIDTH-1:0] crc_out_q, crc_next, eng_init;
   logic [BYTE_W-1:0]    sr;
   logic                 last_q;
   logic [2:0]           bit_idx;
   logic [CNT_W-1:0]     byte_cnt_q;
   logic                 s_ready;
   logic                 accept, cfg_load, eng_load, eng_en, capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      accept    = 1'b0;
      cfg_load  = 1'b0;
      eng_load  = 1'b0;
      eng_en    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            s_ready  = 1'b1;
            cfg_load = cfg_we;
            if (bus.s_valid) begin
               accept    = 1'b1;
               eng_load  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               eng_en = 1'b1;
               if (bit_idx == 3'd0) begin
                  capture   = last_q;
                  state_nxt = last_q ? DONE : GAP;
               end
            end
         end
         GAP: begin
            s_ready = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else if (bus.s_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         DONE: begin
            if (bus.crc_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A config write coinciding with frame start must seed the new init value
   assign eng_init = cfg_load ? cfg_init : init_q;

   crc_bit_engine #(
      .CRC_WIDTH(CRC_WIDTH)
   ) u_engine (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (eng_load),
      .init  (eng_init),
      .en    (eng_en),
      .bit_in(sr[bit_idx]),
      .poly  (poly_q),
      .crc   (crc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poly_q     <= POLY_DEFAULT;
         init_q     <= INIT_DEFAULT;
         xorout_q   <= XOROUT_DEFAULT;
         sr         <= '0;
         last_q     <= 1'b0;
         bit_idx    <= '0;
         byte_cnt_q <= '0;
         crc_out_q  <= '0;
      end else begin
         if (cfg_load) begin
            poly_q   <= cfg_poly;
            init_q   <= cfg_init;
            xorout_q <= cfg_xorout;
         end
         if (accept) begin
            sr      <= bus.s_data;
            last_q  <= bus.s_last;
            bit_idx <= 3'd7;
            if (state == IDLE) begin
               byte_cnt_q <= CNT_W'(1);
            end else if (byte_cnt_q != '1) begin
               byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
         end else if (eng_en) begin
            bit_idx <= bit_idx - 3'd1;
         end
         if (capture) begin
            crc_out_q <= crc_next ^ xorout_q;
         end
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.crc_valid = (state == DONE);
   assign bus.crc_out   = crc_out_q;
   assign cfg_busy      = (state != IDLE);
   assign byte_cnt      = byte_cnt_q;

endmodule

// File: tb/tb_crc_stream_ctrl.sv
// Drives an 8-bit and a 16-bit controller in lockstep against a bitwise CRC model.
module tb_crc_stream_ctrl;
   import crc_ctrl_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic        cfg_we = 1'b0, abort = 1'b0;
   logic        s_valid = 1'b0, s_last = 1'b0, crc_ready = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic [7:0]  cfg_poly8 = 8'h00, cfg_init8 = 8'h00, cfg_xor8 = 8'h00;
   logic [15:0] cfg_poly16 = 16'h0, cfg_init16 = 16'h0, cfg_xor16 = 16'h0;
   logic        cfg_busy8, cfg_busy16;
   logic [15:0] byte_cnt8, byte_cnt16;
   bit          cfg_with_frame = 1'b0;

   logic [31:0] m_poly8, m_init8, m_xor8, m_poly16, m_init16, m_xor16;

   crc_stream_ctrl_if #(.CRC_WIDTH(8))  b8();
   crc_stream_ctrl_if #(.CRC_WIDTH(16)) b16();

   assign b8.s_data     = s_data;
   assign b8.s_valid    = s_valid;
   assign b8.s_last     = s_last;
   assign b8.crc_ready  = crc_ready;
   assign b16.s_data    = s_data;
   assign b16.s_valid   = s_valid;
   assign b16.s_last    = s_last;
   assign b16.crc_ready = crc_ready;

   crc_stream_ctrl #(
      .CRC_WIDTH(8), .POLY_DEFAULT(8'h9B), .INIT_DEFAULT(8'hFF), .XOROUT_DEFAULT(8'h00)
   ) dut8 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_poly(cfg_poly8),
      .cfg_init(cfg_init8), .cfg_xorout(cfg_xor8), .cfg_busy(cfg_busy8),
      .bus(b8.slave), .abort(abort), .byte_cnt(byte_cnt8)
   );

   crc_stream_ctrl #(
      .CRC_WIDTH(16), .POLY_DEFAULT(16'h1021), .INIT_DEFAULT(16'hFFFF), .XOROUT_DEFAULT(16'h0000)
   ) dut16 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_poly(cfg_poly16),
      .cfg_init(cfg_init16), .cfg_xorout(cfg_xor16), .cfg_busy(cfg_busy16),
      .bus(b16.slave), .abort(abort), .byte_cnt(byte_cnt16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plain long-division CRC over the message, MSB first, no augmentation
   function automatic logic [31:0] crc_ref(input int unsigned w, input logic [31:0] poly,
                                           input logic [31:0] init, input logic [31:0] xorout,
                                           input byte_q_t msg);
      longint unsigned mask, c, top, b;
      mask = (64'd1 << w) - 64'd1;
      c    = init & mask;
      foreach (msg[i]) begin
         for (int k = 7; k >= 0; k--) begin
            top = (c >> (w - 1)) & 64'd1;
            b   = (msg[i] >> k) & 64'd1;
            c   = (c << 1) & mask;
            if ((top ^ b) != 0) c = c ^ (poly & mask);
         end
      end
      return 32'((c ^ xorout) & mask);
   endfunction

   task automatic model_defaults();
      m_poly8  = 32'h9B;   m_init8  = 32'hFF;   m_xor8  = 32'h00;
      m_poly16 = 32'h1021; m_init16 = 32'hFFFF; m_xor16 = 32'h0000;
   endtask

   task automatic write_cfg(input logic [7:0] p8, input logic [7:0] i8, input logic [7:0] x8,
                            input logic [15:0] p16, input logic [15:0] i16, input logic [15:0] x16,
                            input bit with_frame);
      cfg_poly8 = p8;   cfg_init8 = i8;   cfg_xor8 = x8;
      cfg_poly16 = p16; cfg_init16 = i16; cfg_xor16 = x16;
      m_poly8 = 32'(p8);   m_init8 = 32'(i8);   m_xor8 = 32'(x8);
      m_poly16 = 32'(p16); m_init16 = 32'(i16); m_xor16 = 32'(x16);
      if (with_frame) begin
         cfg_with_frame = 1'b1;
      end else begin
         cfg_we = 1'b1;
         step();
         cfg_we = 1'b0;
      end
   endtask

   task automatic wait_ready(input string tag, output bit ok);
      int g = 0;
      while (!b8.s_ready && g < 40) begin
         step();
         g++;
      end
      ok = (g < 40);
      if (!ok) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_frame(input string tag, input byte_q_t msg, input int gap_max,
                            input bit poke, input int hold,
                            input bit has8, input logic [31:0] kn8,
                            input bit has16, input logic [31:0] kn16);
      int          first_cyc = 0;
      int          g;
      bit          ok;
      logic [31:0] e8, e16;
      logic [7:0]  held8;
      logic [15:0] held16;
      e8  = crc_ref(8, m_poly8, m_init8, m_xor8, msg);
      e16 = crc_ref(16, m_poly16, m_init16, m_xor16, msg);
      for (int i = 0; i < msg.size(); i++) begin
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) step();
         if (poke && i == 1) begin
            cfg_poly8 = 8'h31; cfg_poly16 = 16'h0031;
            cfg_init8 = 8'h00; cfg_init16 = 16'h0000;
            cfg_xor8  = 8'hA5; cfg_xor16  = 16'hA5A5;
            chk({tag, "_busy_shift"}, 32'(cfg_busy8), 32'd1);
            cfg_we = 1'b1;
            step();
            cfg_we = 1'b0;
            wait_ready(tag, ok);
            if (!ok) return;
            cfg_we = 1'b1;
            step();
            cfg_we = 1'b0;
         end
         s_data  = msg[i];
         s_last  = (i == msg.size() - 1);
         s_valid = 1'b1;
         wait_ready(tag, ok);
         if (!ok) begin
            s_valid = 1'b0;
            return;
         end
         if (i == 0) begin
            first_cyc = int'(cyc);
            cfg_we    = cfg_with_frame;
         end
         step();
         cfg_we         = 1'b0;
         cfg_with_frame = 1'b0;
         s_valid        = 1'b0;
         s_data         = 8'($urandom);
         s_last         = 1'($urandom);
      end
      g = 0;
      while (!b8.crc_valid && g < 200) begin
         step();
         g++;
      end
      if (g >= 200) begin
         chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (gap_max == 0 && !poke) chk({tag, "_latency"}, 32'(int'(cyc) - first_cyc), 32'(9 * msg.size()));
      chk({tag, "_crc8"}, 32'(b8.crc_out), e8);
      chk({tag, "_crc16"}, 32'(b16.crc_out), e16);
      chk({tag, "_valid16"}, 32'(b16.crc_valid), 32'd1);
      if (has8) chk({tag, "_known8"}, 32'(b8.crc_out), kn8);
      if (has16) chk({tag, "_known16"}, 32'(b16.crc_out), kn16);
      chk({tag, "_cnt8"}, 32'(byte_cnt8), 32'(msg.size()));
      chk({tag, "_cnt16"}, 32'(byte_cnt16), 32'(msg.size()));
      held8  = b8.crc_out;
      held16 = b16.crc_out;
      if (hold > 0) begin
         s_valid = 1'b1;
         s_last  = 1'b1;
         s_data  = 8'($urandom);
      end
      for (int h = 0; h < hold; h++) begin
         abort = 1'($urandom);
         step();
         chk({tag, "_hold_crc8"}, 32'(b8.crc_out), 32'(held8));
         chk({tag, "_hold_crc16"}, 32'(b16.crc_out), 32'(held16));
         chk({tag, "_hold_valid"}, 32'(b8.crc_valid), 32'd1);
         chk({tag, "_hold_ready"}, 32'(b8.s_ready), 32'd0);
         chk({tag, "_hold_cnt"}, 32'(byte_cnt8), 32'(msg.size()));
      end
      abort     = 1'b0;
      crc_ready = 1'b1;
      step();
      crc_ready = 1'b0;
      chk({tag, "_rel_valid"}, 32'(b8.crc_valid), 32'd0);
      chk({tag, "_rel_busy"}, 32'(cfg_busy8), 32'd0);
      chk({tag, "_rel_ready"}, 32'(b8.s_ready), 32'd1);
      chk({tag, "_rel_cnt"}, 32'(byte_cnt8), 32'(msg.size()));
      if (hold > 0) begin
         step();
         chk({tag, "_next_busy"}, 32'(cfg_busy8), 32'd1);
         chk({tag, "_next_cnt"}, 32'(byte_cnt8), 32'd1);
         s_valid = 1'b0;
         abort   = 1'b1;
         step();
         abort = 1'b0;
         chk({tag, "_abort_shift_busy"}, 32'(cfg_busy16), 32'd0);
         chk({tag, "_abort_shift_valid"}, 32'(b8.crc_valid), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_crc8"}, 32'(b8.crc_out), 32'd0);
      chk({tag, "_crc16"}, 32'(b16.crc_out), 32'd0);
      chk({tag, "_valid"}, 32'({b16.crc_valid, b8.crc_valid}), 32'd0);
      chk({tag, "_ready"}, 32'({b16.s_ready, b8.s_ready}), 32'd3);
      chk({tag, "_busy"}, 32'({cfg_busy16, cfg_busy8}), 32'd0);
      chk({tag, "_cnt8"}, 32'(byte_cnt8), 32'd0);
      chk({tag, "_cnt16"}, 32'(byte_cnt16), 32'd0);
   endtask

   initial begin
      byte_q_t digits;
      byte_q_t msg;
      bit      ok;
      bit      saw_valid;
      digits = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      model_defaults();

      repeat (3) step();
      check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      step();

      run_frame("defaults", digits, 0, 1'b0, 0, 1'b1, 32'hDA, 1'b1, 32'h29B1);
      run_frame("done_hold", {8'hA7, 8'h3C}, 0, 1'b0, 5, 1'b0, 32'h0, 1'b0, 32'h0);
      run_frame("cfg_ignored", digits, 0, 1'b1, 0, 1'b1, 32'hDA, 1'b1, 32'h29B1);
      run_frame("cfg_kept", {8'h5A}, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Abort in GAP after four bytes
      for (int i = 0; i < 4; i++) begin
         s_data  = digits[i];
         s_last  = 1'b0;
         s_valid = 1'b1;
         wait_ready("abort_gap", ok);
         step();
         s_valid = 1'b0;
      end
      wait_ready("abort_gap", ok);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_gap_busy", 32'({cfg_busy16, cfg_busy8}), 32'd0);
      chk("abort_gap_cnt", 32'(byte_cnt8), 32'd4);
      saw_valid = 1'b0;
      repeat (12) begin
         step();
         saw_valid = saw_valid | b8.crc_valid | b16.crc_valid;
      end
      chk("abort_gap_no_valid", 32'(saw_valid), 32'd0);
      run_frame("after_abort", digits, 0, 1'b0, 0, 1'b1, 32'hDA, 1'b1, 32'h29B1);

      write_cfg(8'h07, 8'h00, 8'h00, 16'h1021, 16'hFFFF, 16'hFFFF, 1'b1);
      run_frame("poly07", digits, 0, 1'b0, 0, 1'b1, 32'hF4, 1'b1, 32'hD64E);
      run_frame("byte01", {8'h01}, 0, 1'b0, 0, 1'b1, 32'h07, 1'b0, 32'h0);
      run_frame("byte00", {8'h00}, 0, 1'b0, 0, 1'b1, 32'h00, 1'b0, 32'h0);

      for (int f = 0; f < 8; f++) begin
         write_cfg(8'($urandom), 8'($urandom), 8'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         msg = {};
         repeat ($urandom_range(5, 1)) msg.push_back(8'($urandom));
         run_frame($sformatf("rand%0d", f), msg, 2, 1'b0, int'($urandom_range(2, 0)),
                   1'b0, 32'h0, 1'b0, 32'h0);
      end

      // Reset asserted mid-SHIFT acts without waiting for a clock edge
      write_cfg(8'h1D, 8'h55, 8'h0F, 16'h8005, 16'h1234, 16'h00FF, 1'b0);
      s_data  = 8'h31;
      s_last  = 1'b0;
      s_valid = 1'b1;
      wait_ready("rst_mid", ok);
      step();
      s_valid = 1'b0;
      step();
      step();
      chk("rst_mid_busy_before", 32'(cfg_busy8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk) rst_n = 1'b1;
      step();
      model_defaults();
      run_frame("after_rst", digits, 0, 1'b0, 0, 1'b1, 32'hDA, 1'b1, 32'h29B1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
